// File: rtl/cva6_hpdcache_st_amo_adapter_pkg.sv
// Shared types and helpers for the CVA6 store/AMO to HPDcache adapter.
package cva6_hpdcache_adapter_pkg;

   // Widest physical address a FIFO entry can carry; narrower addresses are zero-extended
   localparam int unsigned PA_MAX_W = 64;

   typedef enum logic [3:0] {
      AMO_NONE = 4'b0000,
      AMO_LR   = 4'b0001,
      AMO_SC   = 4'b0010,
      AMO_SWAP = 4'b0011,
      AMO_ADD  = 4'b0100,
      AMO_AND  = 4'b0101,
      AMO_OR   = 4'b0110,
      AMO_XOR  = 4'b0111,
      AMO_MAX  = 4'b1000,
      AMO_MAXU = 4'b1001,
      AMO_MIN  = 4'b1010,
      AMO_MINU = 4'b1011,
      AMO_CAS1 = 4'b1100,
      AMO_CAS2 = 4'b1101
   } amo_t;

   typedef enum logic [3:0] {
      HPDCACHE_REQ_LOAD     = 4'h0,
      HPDCACHE_REQ_STORE    = 4'h1,
      HPDCACHE_REQ_AMO_LR   = 4'h4,
      HPDCACHE_REQ_AMO_SC   = 4'h5,
      HPDCACHE_REQ_AMO_SWAP = 4'h6,
      HPDCACHE_REQ_AMO_ADD  = 4'h7,
      HPDCACHE_REQ_AMO_AND  = 4'h8,
      HPDCACHE_REQ_AMO_OR   = 4'h9,
      HPDCACHE_REQ_AMO_XOR  = 4'ha,
      HPDCACHE_REQ_AMO_MAX  = 4'hb,
      HPDCACHE_REQ_AMO_MAXU = 4'hc,
      HPDCACHE_REQ_AMO_MIN  = 4'hd,
      HPDCACHE_REQ_AMO_MINU = 4'he
   } hpdcache_req_op_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRAIN = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_ACK   = 3'd4
   } fsm_state_t;

   typedef struct packed {
      logic [PA_MAX_W-1:0] addr;
      logic [63:0]         wdata;
      logic [7:0]          be;
      logic [1:0]          size;
      logic                uc;
   } st_entry_t;

   typedef struct packed {
      logic             valid;
      hpdcache_req_op_t op;
   } amo_map_t;

   // Core AMO opcode to cache opcode; valid is low for ops the cache cannot execute
   function automatic amo_map_t amo_to_req_op(amo_t op);
      amo_map_t m;
      m.valid = 1'b1;
      m.op    = HPDCACHE_REQ_LOAD;
      case (op)
         AMO_LR:   m.op = HPDCACHE_REQ_AMO_LR;
         AMO_SC:   m.op = HPDCACHE_REQ_AMO_SC;
         AMO_SWAP: m.op = HPDCACHE_REQ_AMO_SWAP;
         AMO_ADD:  m.op = HPDCACHE_REQ_AMO_ADD;
         AMO_AND:  m.op = HPDCACHE_REQ_AMO_AND;
         AMO_OR:   m.op = HPDCACHE_REQ_AMO_OR;
         AMO_XOR:  m.op = HPDCACHE_REQ_AMO_XOR;
         AMO_MAX:  m.op = HPDCACHE_REQ_AMO_MAX;
         AMO_MAXU: m.op = HPDCACHE_REQ_AMO_MAXU;
         AMO_MIN:  m.op = HPDCACHE_REQ_AMO_MIN;
         AMO_MINU: m.op = HPDCACHE_REQ_AMO_MINU;
         default:  m.valid = 1'b0;
      endcase
      return m;
   endfunction

   // All-ones transaction ID reserved for the single outstanding AMO
   function automatic logic [63:0] AMO_TID_ALL_ONES(int unsigned tid_w);
      return (tid_w >= 64) ? '1 : ((64'd1 << tid_w) - 64'd1);
   endfunction

endpackage

// File: rtl/cva6_hpdcache_st_amo_adapter_if.sv
// HPDcache request/response port bundle seen by the store/AMO adapter.
interface cva6_hpdcache_st_amo_adapter_if
   import cva6_hpdcache_adapter_pkg::*;
#(
   parameter int unsigned ADDR_W   = 56,
   parameter int unsigned OFFSET_W = 12,
   parameter int unsigned SID_W    = 3,
   parameter int unsigned TID_W    = 6
);
   logic                       req_valid;
   logic                       req_ready;
   hpdcache_req_op_t           req_op;
   logic [OFFSET_W-1:0]        req_addr_offset;
   logic [ADDR_W-OFFSET_W-1:0] req_addr_tag;
   logic [63:0]                req_wdata;
   logic [7:0]                 req_be;
   logic [2:0]                 req_size;
   logic [SID_W-1:0]           req_sid;
   logic [TID_W-1:0]           req_tid;
   logic                       req_need_rsp;
   logic                       req_uc;
   logic                       rsp_valid;
   logic [TID_W-1:0]           rsp_tid;
   logic [63:0]                rsp_rdata;

   modport master (
      output req_valid, req_op, req_addr_offset, req_addr_tag, req_wdata, req_be,
             req_size, req_sid, req_tid, req_need_rsp, req_uc,
      input  req_ready, rsp_valid, rsp_tid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_op, req_addr_offset, req_addr_tag, req_wdata, req_be,
             req_size, req_sid, req_tid, req_need_rsp, req_uc,
      output req_ready, rsp_valid, rsp_tid, rsp_rdata
   );
endinterface

// File: rtl/cva6_hpdcache_st_amo_adapter_fifo.sv
// Generic registered FIFO with registered full flag and occupancy count.
module hpdcache_adapter_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  T                 data_i,
   input  logic             pop_i,
   output T                 data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q;

   assign count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
   assign data_o  = mem[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   // Pointer, occupancy and full-flag bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
      end
   end

   // Entry storage; contents are only meaningful below the occupancy count, so no reset
   always_ff @(posedge clk_i) begin
      if (push_i) mem[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/cva6_hpdcache_st_amo_adapter.sv
// Buffered store / AMO adapter from the CVA6 store unit to the HPDcache request port.
module cva6_hpdcache_st_amo_adapter
   import cva6_hpdcache_adapter_pkg::*;
#(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned ADDR_W   = 56,
   parameter int unsigned OFFSET_W = 12,
   parameter int unsigned SID_W    = 3,
   parameter int unsigned TID_W    = 6,
   parameter int unsigned ST_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [SID_W-1:0]  sid_i,
   input  logic              st_req_i,
   output logic              st_gnt_o,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [63:0]       st_wdata_i,
   input  logic [7:0]        st_be_i,
   input  logic [1:0]        st_size_i,
   input  logic              st_uc_i,
   input  logic              amo_req_i,
   input  amo_t              amo_op_i,
   input  logic [1:0]        amo_size_i,
   input  logic [ADDR_W-1:0] amo_addr_i,
   input  logic [XLEN-1:0]   amo_operand_i,
   input  logic              amo_uc_i,
   output logic              amo_ack_o,
   output logic [XLEN-1:0]   amo_result_o,
   cva6_hpdcache_st_amo_adapter_if.master hp
);
   localparam logic [TID_W-1:0] AMO_TID = TID_W'(AMO_TID_ALL_ONES(TID_W));

   fsm_state_t            state_q, state_d;
   st_entry_t             st_in, st_head;
   logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [$clog2(ST_DEPTH):0] unused_st_count;
   logic                  st_sel, rsp_hit, amo_dbl;
   amo_map_t              amo_map;
   logic signed [31:0]    rsp_word;
   logic signed [63:0]    rsp_word_sext;
   logic [63:0]           rsp_val;
   logic [XLEN-1:0]       result_q;

   assign st_in = '{addr: PA_MAX_W'(st_addr_i), wdata: st_wdata_i, be: st_be_i,
                    size: st_size_i, uc: st_uc_i};

   // A pending AMO blocks new stores so nothing younger can overtake it
   assign st_gnt_o  = st_req_i & ~fifo_full & (state_q == ST_IDLE) & ~amo_req_i;
   assign fifo_push = st_gnt_o;
   assign st_sel    = ~fifo_empty & ((state_q == ST_IDLE) | (state_q == ST_DRAIN));
   assign fifo_pop  = st_sel & hp.req_ready;

   hpdcache_adapter_fifo #(
      .DEPTH (ST_DEPTH),
      .T     (st_entry_t)
   ) i_st_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (st_in),
      .pop_i   (fifo_pop),
      .data_o  (st_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (unused_st_count)
   );

   if (ADDR_W < PA_MAX_W) begin : g_addr_pad
      logic unused_addr_pad;
      assign unused_addr_pad = ^st_head.addr[PA_MAX_W-1:ADDR_W];
   end

   assign amo_map = amo_to_req_op(amo_op_i);
   assign amo_dbl = (XLEN == 64) && (amo_size_i == 2'b11);
   assign rsp_hit = hp.rsp_valid && (hp.rsp_tid == AMO_TID);

   // Word results come from the lane picked by addr[2] and are sign-extended
   assign rsp_word      = amo_addr_i[2] ? hp.rsp_rdata[63:32] : hp.rsp_rdata[31:0];
   assign rsp_word_sext = rsp_word;
   assign rsp_val       = amo_dbl ? hp.rsp_rdata : rsp_word_sext;

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: drain older stores, issue the AMO, wait for its tagged response
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (amo_req_i)   state_d = ST_DRAIN;
         ST_DRAIN: if (fifo_empty)  state_d = amo_map.valid ? ST_ISSUE : ST_ACK;
         ST_ISSUE: if (hp.req_ready) state_d = ST_WAIT;
         ST_WAIT:  if (rsp_hit)     state_d = ST_ACK;
         ST_ACK:                    state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: FIFO head in IDLE/DRAIN, the AMO in ISSUE, otherwise idle zeros
   always_comb begin
      hp.req_valid       = 1'b0;
      hp.req_op          = HPDCACHE_REQ_LOAD;
      hp.req_addr_offset = '0;
      hp.req_addr_tag    = '0;
      hp.req_wdata       = '0;
      hp.req_be          = '0;
      hp.req_size        = '0;
      hp.req_sid         = '0;
      hp.req_tid         = '0;
      hp.req_need_rsp    = 1'b0;
      hp.req_uc          = 1'b0;
      amo_ack_o          = (state_q == ST_ACK);
      if (st_sel) begin
         hp.req_valid       = 1'b1;
         hp.req_op          = HPDCACHE_REQ_STORE;
         hp.req_addr_offset = st_head.addr[OFFSET_W-1:0];
         hp.req_addr_tag    = st_head.addr[ADDR_W-1:OFFSET_W];
         hp.req_wdata       = st_head.wdata;
         hp.req_be          = st_head.be;
         hp.req_size        = {1'b0, st_head.size};
         hp.req_sid         = sid_i;
         hp.req_uc          = st_head.uc;
      end else if (state_q == ST_ISSUE) begin
         hp.req_valid       = 1'b1;
         hp.req_op          = amo_map.op;
         hp.req_addr_offset = amo_addr_i[OFFSET_W-1:0];
         hp.req_addr_tag    = amo_addr_i[ADDR_W-1:OFFSET_W];
         hp.req_wdata       = amo_dbl ? 64'(amo_operand_i) : {2{amo_operand_i[31:0]}};
         hp.req_be          = amo_dbl ? 8'hFF : (amo_addr_i[2] ? 8'hF0 : 8'h0F);
         hp.req_size        = {1'b0, amo_size_i};
         hp.req_sid         = sid_i;
         hp.req_tid         = AMO_TID;
         hp.req_need_rsp    = 1'b1;
         hp.req_uc          = amo_uc_i;
      end
   end

   // AMO result capture; unsupported ops complete with a zero result
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_q <= '0;
      end else if ((state_q == ST_WAIT) && rsp_hit) begin
         result_q <= rsp_val[XLEN-1:0];
      end else if ((state_q == ST_DRAIN) && fifo_empty && !amo_map.valid) begin
         result_q <= '0;
      end
   end

   assign amo_result_o = result_q;
endmodule

// File: tb/tb_cva6_hpdcache_st_amo_adapter.sv
// Directed bench for the store/AMO adapter: store streaming, FIFO full, AMO ordering/data, reset.
module tb_cva6_hpdcache_st_amo_adapter;
   import cva6_hpdcache_adapter_pkg::*;

   localparam int unsigned XLEN = 64, ADDR_W = 56, OFFSET_W = 12;
   localparam int unsigned SID_W = 3, TID_W = 6, ST_DEPTH = 4;

   logic              clk, rst;
   logic [SID_W-1:0]  sid;
   logic              st_req, st_gnt;
   logic [ADDR_W-1:0] st_addr;
   logic [63:0]       st_wdata;
   logic [7:0]        st_be;
   logic [1:0]        st_size;
   logic              st_uc;
   logic              amo_req;
   amo_t              amo_op;
   logic [1:0]        amo_size;
   logic [ADDR_W-1:0] amo_addr;
   logic [XLEN-1:0]   amo_operand;
   logic              amo_uc, amo_ack;
   logic [XLEN-1:0]   amo_result;

   int n_tests = 0;
   int n_fail  = 0;

   cva6_hpdcache_st_amo_adapter_if #(
      .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .SID_W(SID_W), .TID_W(TID_W)
   ) hp ();

   cva6_hpdcache_st_amo_adapter #(
      .XLEN(XLEN), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W),
      .SID_W(SID_W), .TID_W(TID_W), .ST_DEPTH(ST_DEPTH)
   ) dut (
      .clk_i(clk), .rst_i(rst), .sid_i(sid),
      .st_req_i(st_req), .st_gnt_o(st_gnt), .st_addr_i(st_addr), .st_wdata_i(st_wdata),
      .st_be_i(st_be), .st_size_i(st_size), .st_uc_i(st_uc),
      .amo_req_i(amo_req), .amo_op_i(amo_op), .amo_size_i(amo_size), .amo_addr_i(amo_addr),
      .amo_operand_i(amo_operand), .amo_uc_i(amo_uc), .amo_ack_o(amo_ack),
      .amo_result_o(amo_result), .hp(hp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [ADDR_W-1:0] sa(int i);
      return ADDR_W'(64'h0000_0000_8000_1000 + 64'(i * 8));
   endfunction

   function automatic logic [63:0] sw(int i);
      return 64'hA5A5_0000_0000_0000 | 64'(i);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive_st(int i);
      st_req   = 1'b1;
      st_addr  = sa(i);
      st_wdata = sw(i);
      st_be    = 8'hFF;
      st_size  = 2'b11;
      st_uc    = 1'b0;
   endtask

   task automatic chk_head(input string tag, int i);
      chk({tag, ".valid"}, 64'(hp.req_valid), 64'd1);
      chk({tag, ".addr"}, 64'({hp.req_addr_tag, hp.req_addr_offset}), 64'(sa(i)));
      chk({tag, ".wdata"}, hp.req_wdata, sw(i));
      chk({tag, ".op"}, 64'(hp.req_op), 64'(HPDCACHE_REQ_STORE));
      chk({tag, ".tid"}, 64'(hp.req_tid), 64'd0);
      chk({tag, ".need_rsp"}, 64'(hp.req_need_rsp), 64'd0);
      chk({tag, ".sid"}, 64'(hp.req_sid), 64'd5);
      chk({tag, ".size"}, 64'(hp.req_size), 64'd3);
   endtask

   initial begin
      rst = 1'b1; sid = 3'd5;
      st_req = 0; st_addr = '0; st_wdata = '0; st_be = '0; st_size = '0; st_uc = 0;
      amo_req = 0; amo_op = AMO_NONE; amo_size = '0; amo_addr = '0; amo_operand = '0; amo_uc = 0;
      hp.req_ready = 0; hp.rsp_valid = 0; hp.rsp_tid = '0; hp.rsp_rdata = '0;
      cyc(); cyc();
      smp();
      chk("rst.req_valid", 64'(hp.req_valid), 64'd0);
      chk("rst.gnt", 64'(st_gnt), 64'd0);
      chk("rst.ack", 64'(amo_ack), 64'd0);
      chk("rst.result", amo_result, 64'd0);
      chk("rst.tid", 64'(hp.req_tid), 64'd0);
      chk("rst.be", 64'(hp.req_be), 64'd0);
      cyc();
      rst = 1'b0;

      // back-to-back stores with the cache always ready
      hp.req_ready = 1;
      drive_st(0);
      smp(); chk("b2b.gnt0", 64'(st_gnt), 64'd1); chk("b2b.valid0", 64'(hp.req_valid), 64'd0);
      cyc();
      for (int i = 1; i < 4; i++) begin
         drive_st(i);
         smp(); chk("b2b.gnt", 64'(st_gnt), 64'd1); chk_head("b2b.head", i - 1);
         cyc();
      end
      st_req = 0;
      smp(); chk_head("b2b.last", 3); chk("b2b.gnt4", 64'(st_gnt), 64'd0);
      cyc();
      smp(); chk("b2b.empty", 64'(hp.req_valid), 64'd0);

      // FIFO full: five stores, cache stalled
      cyc();
      hp.req_ready = 0;
      for (int i = 10; i < 14; i++) begin
         drive_st(i);
         smp(); chk("full.fill_gnt", 64'(st_gnt), 64'd1);
         cyc();
      end
      drive_st(14);
      smp(); chk("full.gnt_blocked", 64'(st_gnt), 64'd0); chk_head("full.head_stall", 10);
      cyc();
      hp.req_ready = 1;
      smp(); chk("full.gnt_on_pop", 64'(st_gnt), 64'd0); chk_head("full.head_pop", 10);
      cyc();
      smp(); chk("full.gnt_after_pop", 64'(st_gnt), 64'd1); chk_head("full.h11", 11);
      cyc();
      st_req = 0;
      smp(); chk_head("full.h12", 12); cyc();
      smp(); chk_head("full.h13", 13); cyc();
      smp(); chk_head("full.h14", 14); cyc();
      smp(); chk("full.empty", 64'(hp.req_valid), 64'd0);

      // AMO_ADD word behind two buffered stores
      cyc();
      hp.req_ready = 0;
      drive_st(20); smp(); chk("ord.gnt20", 64'(st_gnt), 64'd1); cyc();
      drive_st(21); smp(); chk("ord.gnt21", 64'(st_gnt), 64'd1); cyc();
      drive_st(22);
      amo_req = 1; amo_op = AMO_ADD; amo_size = 2'b10;
      amo_addr = 56'h00_0000_4000_0004; amo_operand = 64'h1; amo_uc = 0;
      smp(); chk("ord.amo_prio_gnt", 64'(st_gnt), 64'd0); chk_head("ord.h20_idle", 20);
      cyc();
      st_req = 0; hp.req_ready = 1;
      smp(); chk_head("ord.h20_drain", 20); cyc();
      smp(); chk_head("ord.h21_drain", 21); cyc();
      smp(); chk("ord.drained_no_req", 64'(hp.req_valid), 64'd0); cyc();
      hp.req_ready = 0;
      smp();
      chk("amo.valid", 64'(hp.req_valid), 64'd1);
      chk("amo.op", 64'(hp.req_op), 64'h7);
      chk("amo.tid", 64'(hp.req_tid), 64'h3F);
      chk("amo.need_rsp", 64'(hp.req_need_rsp), 64'd1);
      chk("amo.be", 64'(hp.req_be), 64'hF0);
      chk("amo.wdata", hp.req_wdata, 64'h0000_0001_0000_0001);
      chk("amo.size", 64'(hp.req_size), 64'd2);
      chk("amo.addr", 64'({hp.req_addr_tag, hp.req_addr_offset}), 64'h0000_0000_4000_0004);
      cyc();
      hp.req_ready = 1;
      smp(); chk("amo.stall_valid", 64'(hp.req_valid), 64'd1);
      chk("amo.stall_be", 64'(hp.req_be), 64'hF0);
      chk("amo.stall_wdata", hp.req_wdata, 64'h0000_0001_0000_0001);
      cyc();
      hp.req_ready = 0;
      hp.rsp_valid = 1; hp.rsp_tid = 6'd5; hp.rsp_rdata = 64'h1234;
      smp(); chk("wait.no_req", 64'(hp.req_valid), 64'd0); chk("wait.ack0", 64'(amo_ack), 64'd0);
      cyc();
      hp.rsp_tid = 6'h3F; hp.rsp_rdata = 64'hFFFF_FFFE_0000_0000;
      smp(); chk("wait.tid5_ignored", 64'(amo_ack), 64'd0);
      cyc();
      hp.rsp_valid = 0;
      smp(); chk("amo.ack", 64'(amo_ack), 64'd1);
      chk("amo.result", amo_result, 64'hFFFF_FFFF_FFFF_FFFE);
      cyc();
      amo_req = 0;
      smp(); chk("amo.ack_pulse", 64'(amo_ack), 64'd0);

      // unsupported AMO after one store
      cyc();
      hp.req_ready = 1;
      drive_st(30); smp(); chk("none.gnt", 64'(st_gnt), 64'd1); cyc();
      st_req = 0; amo_req = 1; amo_op = AMO_NONE; amo_size = 2'b11;
      smp(); chk_head("none.h30", 30); cyc();
      smp(); chk("none.drain_no_req", 64'(hp.req_valid), 64'd0);
      chk("none.drain_ack0", 64'(amo_ack), 64'd0);
      cyc();
      smp(); chk("none.ack", 64'(amo_ack), 64'd1);
      chk("none.result", amo_result, 64'd0);
      chk("none.no_req", 64'(hp.req_valid), 64'd0);
      cyc();
      amo_req = 0;
      smp(); chk("none.ack_pulse", 64'(amo_ack), 64'd0);

      // double-word AMO_OR
      cyc();
      amo_req = 1; amo_op = AMO_OR; amo_size = 2'b11;
      amo_addr = 56'h00_0000_4000_0008; amo_operand = 64'h0123_4567_89AB_CDEF;
      smp(); chk("dbl.idle_no_req", 64'(hp.req_valid), 64'd0); cyc();
      smp(); chk("dbl.drain_no_req", 64'(hp.req_valid), 64'd0); cyc();
      smp();
      chk("dbl.valid", 64'(hp.req_valid), 64'd1);
      chk("dbl.op", 64'(hp.req_op), 64'h9);
      chk("dbl.be", 64'(hp.req_be), 64'hFF);
      chk("dbl.wdata", hp.req_wdata, 64'h0123_4567_89AB_CDEF);
      chk("dbl.size", 64'(hp.req_size), 64'd3);
      cyc();
      hp.rsp_valid = 1; hp.rsp_tid = 6'h3F; hp.rsp_rdata = 64'h8000_0000_0000_0001;
      smp(); chk("dbl.wait_ack0", 64'(amo_ack), 64'd0); cyc();
      hp.rsp_valid = 0;
      smp(); chk("dbl.ack", 64'(amo_ack), 64'd1);
      chk("dbl.result", amo_result, 64'h8000_0000_0000_0001);
      cyc();
      amo_req = 0;

      // reset with three stores buffered
      hp.req_ready = 0;
      for (int i = 40; i < 43; i++) begin
         drive_st(i); smp(); chk("rst3.fill_gnt", 64'(st_gnt), 64'd1); cyc();
      end
      st_req = 0; rst = 1;
      smp(); chk("rst3.valid", 64'(hp.req_valid), 64'd0); chk("rst3.ack", 64'(amo_ack), 64'd0);
      cyc();
      rst = 0; drive_st(43);
      smp(); chk("rst3.gnt_after", 64'(st_gnt), 64'd1); chk("rst3.dropped", 64'(hp.req_valid), 64'd0);
      cyc();
      st_req = 0; hp.req_ready = 1;
      smp(); chk_head("rst3.h43", 43); cyc();
      smp(); chk("rst3.empty", 64'(hp.req_valid), 64'd0);

      // reset while waiting for an AMO response
      cyc();
      amo_req = 1; amo_op = AMO_SWAP; amo_size = 2'b10;
      amo_addr = 56'h00_0000_4000_0010; amo_operand = 64'hDEAD_BEEF_1234_5678;
      cyc(); cyc();
      smp();
      chk("swap.be", 64'(hp.req_be), 64'h0F);
      chk("swap.wdata", hp.req_wdata, 64'h1234_5678_1234_5678);
      chk("swap.op", 64'(hp.req_op), 64'h6);
      cyc();
      smp(); chk("rstw.wait_no_req", 64'(hp.req_valid), 64'd0); chk("rstw.wait_ack0", 64'(amo_ack), 64'd0);
      cyc();
      rst = 1; amo_req = 0;
      smp(); chk("rstw.valid", 64'(hp.req_valid), 64'd0);
      chk("rstw.ack", 64'(amo_ack), 64'd0);
      chk("rstw.result", amo_result, 64'd0);
      cyc();
      rst = 0; drive_st(50);
      smp(); chk("rstw.gnt_idle", 64'(st_gnt), 64'd1);
      cyc();
      st_req = 0;
      smp(); chk_head("rstw.h50", 50);
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
